// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm time setter.
//   state_t         : edit FSM states
//   FIELD_HOUR/MIN  : encoding of the edit_field output
//   *_MAX_BCD       : wrap limits for the per-field BCD arithmetic
//   to_bcd8()       : two-digit binary to BCD, used for reset constants
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EDIT_HOUR,
        EDIT_MIN
    } state_t;

    localparam logic FIELD_HOUR = 1'b0;
    localparam logic FIELD_MIN  = 1'b1;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;

    localparam logic [7:0] HOUR_MAX_BCD = 8'h23;
    localparam logic [7:0] MIN_MAX_BCD  = 8'h59;

    // Valid for 0..99 only; callers pass hour/minute constants.
    function automatic logic [7:0] to_bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/alarm_time_setter_if.sv
// Alarm-time bus between the board controls, the setter and its consumers.
//   set_mode, btn_*   : debounced, clk-synchronous control levels
//   a_first..a_fourth : committed alarm HH:MM in BCD (min ones .. hour tens)
//   e_first..e_fourth : shadow digits shown while editing, same order
//   editing, edit_field, alarm_updated : edit status and commit strobe
// master = the setter (drives the alarm digits), slave = controls/consumers.
interface alarm_time_setter_if;
    logic       set_mode;
    logic       btn_next;
    logic       btn_up;
    logic       btn_down;
    logic       btn_confirm;
    logic [3:0] a_first;
    logic [3:0] a_second;
    logic [3:0] a_third;
    logic [3:0] a_fourth;
    logic [3:0] e_first;
    logic [3:0] e_second;
    logic [3:0] e_third;
    logic [3:0] e_fourth;
    logic       editing;
    logic       edit_field;
    logic       alarm_updated;

    modport master (
        input  set_mode, btn_next, btn_up, btn_down, btn_confirm,
        output a_first, a_second, a_third, a_fourth,
        output e_first, e_second, e_third, e_fourth,
        output editing, edit_field, alarm_updated
    );

    modport slave (
        output set_mode, btn_next, btn_up, btn_down, btn_confirm,
        input  a_first, a_second, a_third, a_fourth,
        input  e_first, e_second, e_third, e_fourth,
        input  editing, edit_field, alarm_updated
    );
endinterface

// File: rtl/btn_repeat.sv
// Rising-edge detect plus hold-to-repeat for one button.
//   clk, reset : clock, asynchronous active-high reset
//   btn        : debounced button level
//   clear      : suppress stepping and disarm the repeat counter
//   step       : one-cycle step strobe (combinational, same cycle as the edge)
// A step fires on the rising edge, then HOLD_CYCLES after it, then every
// REPEAT_CYCLES while the button stays high. Once cleared, a held button
// stays silent until it is released and pressed again.
module btn_repeat #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic clear,
    output logic step
);
    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic             btn_prev_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             rpt_reg;      // past the initial hold, in repeat phase

    logic rise;
    logic armed;
    logic hit;

    assign rise  = btn & ~btn_prev_reg;
    // Zero means "not counting": idle, released or cleared.
    assign armed = (cnt_reg != '0);
    assign hit   = rpt_reg ? (cnt_reg == CNT_W'(REPEAT_CYCLES))
                           : (cnt_reg == CNT_W'(HOLD_CYCLES));
    assign step  = ~clear & (rise | (btn & armed & hit));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_prev_reg <= 1'b0;
            cnt_reg      <= '0;
            rpt_reg      <= 1'b0;
        end else begin
            btn_prev_reg <= btn;
            if (clear || !btn) begin
                cnt_reg <= '0;
                rpt_reg <= 1'b0;
            end else if (rise) begin
                cnt_reg <= CNT_W'(1);
                rpt_reg <= 1'b0;
            end else if (armed) begin
                if (hit) begin
                    cnt_reg <= CNT_W'(1);
                    rpt_reg <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: rtl/alarm_time_setter.sv
// Alarm time setter: edits a shadow HH:MM with the board buttons and commits
// it atomically to the alarm digits on confirm.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : alarm_time_setter_if.master (buttons in, a_*/e_*/status out)
// The committed registers only change on confirm or reset, so the comparator
// never sees a half-edited time. Leaving set mode without confirming drops
// the shadow.
module alarm_time_setter
    import alarm_pkg::*;
#(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int RESET_HOUR    = 7,
    parameter int RESET_MIN     = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    alarm_time_setter_if.master    bus
);
    localparam logic [7:0] RESET_HOUR_BCD = to_bcd8(RESET_HOUR);
    localparam logic [7:0] RESET_MIN_BCD  = to_bcd8(RESET_MIN);

    state_t     state_reg;
    logic [7:0] a_hour_reg, a_min_reg;
    logic [7:0] e_hour_reg, e_min_reg;
    logic       editing_reg, edit_field_reg, alarm_updated_reg;
    logic       set_mode_prev_reg, next_prev_reg, confirm_prev_reg;

    logic       set_mode_rise, next_rise, confirm_rise;
    logic       step_clear;
    logic [1:0] btn_vec;    // [0] = up, [1] = down
    logic [1:0] step_vec;

    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up,
                                            input logic [7:0] max_bcd);
        logic [7:0] r;
        if (up) begin
            if (v == max_bcd)          r = 8'h00;
            else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
            else                       r = {v[7:4], v[3:0] + 4'd1};
        end else begin
            if (v == 8'h00)            r = max_bcd;
            else if (v[3:0] == 4'd0)   r = {v[7:4] - 4'd1, 4'd9};
            else                       r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    assign set_mode_rise = bus.set_mode & ~set_mode_prev_reg;
    assign next_rise     = bus.btn_next & ~next_prev_reg;
    assign confirm_rise  = bus.btn_confirm & ~confirm_prev_reg;

    // Anything that outranks a step also disarms the repeat counters, so a
    // field switch or an up+down chord restarts the hold timing.
    assign step_clear = (state_reg == IDLE) | ~bus.set_mode | confirm_rise |
                        next_rise | (bus.btn_up & bus.btn_down);

    assign btn_vec = {bus.btn_down, bus.btn_up};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rep
            btn_repeat #(
                .HOLD_CYCLES   (HOLD_CYCLES),
                .REPEAT_CYCLES (REPEAT_CYCLES)
            ) u_btn_repeat (
                .clk   (clk),
                .reset (reset),
                .btn   (btn_vec[gi]),
                .clear (step_clear),
                .step  (step_vec[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            a_hour_reg        <= RESET_HOUR_BCD;
            a_min_reg         <= RESET_MIN_BCD;
            e_hour_reg        <= RESET_HOUR_BCD;
            e_min_reg         <= RESET_MIN_BCD;
            editing_reg       <= 1'b0;
            edit_field_reg    <= FIELD_HOUR;
            alarm_updated_reg <= 1'b0;
            set_mode_prev_reg <= 1'b0;
            next_prev_reg     <= 1'b0;
            confirm_prev_reg  <= 1'b0;
        end else begin
            set_mode_prev_reg <= bus.set_mode;
            next_prev_reg     <= bus.btn_next;
            confirm_prev_reg  <= bus.btn_confirm;
            alarm_updated_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // Shadow tracks the committed time so entering edit
                    // mode always starts from the current alarm.
                    e_hour_reg <= a_hour_reg;
                    e_min_reg  <= a_min_reg;
                    if (set_mode_rise) begin
                        state_reg      <= EDIT_HOUR;
                        editing_reg    <= 1'b1;
                        edit_field_reg <= FIELD_HOUR;
                    end
                end
                EDIT_HOUR, EDIT_MIN: begin
                    if (!bus.set_mode) begin
                        state_reg      <= IDLE;
                        e_hour_reg     <= a_hour_reg;
                        e_min_reg      <= a_min_reg;
                        editing_reg    <= 1'b0;
                        edit_field_reg <= FIELD_HOUR;
                    end else if (confirm_rise) begin
                        // Pre-step shadow is committed; any same-cycle step is dropped.
                        a_hour_reg        <= e_hour_reg;
                        a_min_reg         <= e_min_reg;
                        alarm_updated_reg <= 1'b1;
                        state_reg         <= IDLE;
                        editing_reg       <= 1'b0;
                        edit_field_reg    <= FIELD_HOUR;
                    end else if (next_rise) begin
                        if (state_reg == EDIT_HOUR) begin
                            state_reg      <= EDIT_MIN;
                            edit_field_reg <= FIELD_MIN;
                        end else begin
                            state_reg      <= EDIT_HOUR;
                            edit_field_reg <= FIELD_HOUR;
                        end
                    end else if (step_vec[0] || step_vec[1]) begin
                        if (state_reg == EDIT_HOUR)
                            e_hour_reg <= bcd_step(e_hour_reg, step_vec[0], HOUR_MAX_BCD);
                        else
                            e_min_reg  <= bcd_step(e_min_reg, step_vec[0], MIN_MAX_BCD);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.a_first       = a_min_reg[3:0];
    assign bus.a_second      = a_min_reg[7:4];
    assign bus.a_third       = a_hour_reg[3:0];
    assign bus.a_fourth      = a_hour_reg[7:4];
    assign bus.e_first       = e_min_reg[3:0];
    assign bus.e_second      = e_min_reg[7:4];
    assign bus.e_third       = e_hour_reg[3:0];
    assign bus.e_fourth      = e_hour_reg[7:4];
    assign bus.editing       = editing_reg;
    assign bus.edit_field    = edit_field_reg;
    assign bus.alarm_updated = alarm_updated_reg;
endmodule
